// File: rtl/useq_controller.sv
// Run/halt controller for a 4-bit microsequencer with a writable control store
// and two writable dispatch tables (D1/D2). Tables are writable only while idle.
module useq_controller #(
  parameter int UPC_W = 4,
  parameter int INP_W = 2,
  parameter int BC_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [INP_W-1:0] inp,
  input  logic             inp_valid,
  input  logic             ucode_we,
  input  logic [UPC_W-1:0] ucode_addr,
  input  logic [BC_W-1:0]  ucode_data,
  input  logic             disp_we,
  input  logic             disp_sel,
  input  logic [INP_W-1:0] disp_addr,
  input  logic [UPC_W-1:0] disp_data,
  output logic [UPC_W-1:0] upc,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic             cfg_err
);

  localparam int N_UC = 2 ** UPC_W;
  localparam int N_D  = 2 ** INP_W;

  localparam logic [BC_W-1:0] BC_SEQ   = BC_W'(0);
  localparam logic [BC_W-1:0] BC_DISP1 = BC_W'(1);
  localparam logic [BC_W-1:0] BC_DISP2 = BC_W'(2);
  localparam logic [BC_W-1:0] BC_END   = BC_W'(3);
  localparam logic [BC_W-1:0] BC_WAIT  = BC_W'(4);

  typedef enum logic {
    MODE_IDLE,
    MODE_RUN
  } mode_t;

  mode_t            r_mode;
  logic [UPC_W-1:0] r_upc;
  logic             r_wr_rej;
  logic [BC_W-1:0]  r_ucode [N_UC];
  logic [UPC_W-1:0] r_d1    [N_D];
  logic [UPC_W-1:0] r_d2    [N_D];

  logic             w_run;
  logic [BC_W-1:0]  w_code;
  logic             w_illegal;
  logic             w_end;
  logic             w_gated;
  logic [UPC_W-1:0] w_upc_step;

  function automatic logic [BC_W-1:0] ucode_dflt(input int idx);
    case (idx)
      0, 1, 4, 5: return BC_SEQ;
      2:          return BC_DISP1;
      6:          return BC_DISP2;
      8:          return BC_WAIT;
      default:    return BC_END;
    endcase
  endfunction

  function automatic logic [UPC_W-1:0] d1_dflt(input int idx);
    case (idx)
      0:       return UPC_W'(4);
      1:       return UPC_W'(6);
      default: return UPC_W'(8);
    endcase
  endfunction

  function automatic logic [UPC_W-1:0] d2_dflt(input int idx);
    case (idx)
      0:       return UPC_W'(7);
      1:       return UPC_W'(9);
      default: return UPC_W'(3);
    endcase
  endfunction

  assign w_run     = (r_mode == MODE_RUN);
  assign w_code    = r_ucode[r_upc];
  assign w_illegal = (w_code > BC_WAIT);
  assign w_end     = w_run && ((w_code == BC_END) || w_illegal);
  assign w_gated   = (w_code == BC_DISP1) || (w_code == BC_DISP2) || (w_code == BC_WAIT);

  always_comb begin
    w_upc_step = r_upc;
    case (w_code)
      BC_SEQ:   w_upc_step = r_upc + UPC_W'(1);
      BC_DISP1: if (inp_valid) w_upc_step = r_d1[inp];
      BC_DISP2: if (inp_valid) w_upc_step = r_d2[inp];
      BC_WAIT:  if (inp_valid) w_upc_step = r_upc + UPC_W'(1);
      default:  w_upc_step = r_upc;
    endcase
  end

  // Mode FSM; upc only leaves 0 while running, so entering RUN needs no upc update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode   <= MODE_IDLE;
      r_upc    <= '0;
      r_wr_rej <= 1'b0;
    end else begin
      r_wr_rej <= w_run && (ucode_we || disp_we);
      case (r_mode)
        MODE_IDLE: begin
          if (start) r_mode <= MODE_RUN;
        end
        MODE_RUN: begin
          if (w_end) begin
            r_mode <= MODE_IDLE;
            r_upc  <= '0;
          end else begin
            r_upc  <= w_upc_step;
          end
        end
        default: r_mode <= MODE_IDLE;
      endcase
    end
  end

  // Table writes commit only in IDLE; reset restores the factory contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_UC; i++) r_ucode[i] <= ucode_dflt(i);
      for (int i = 0; i < N_D; i++) begin
        r_d1[i] <= d1_dflt(i);
        r_d2[i] <= d2_dflt(i);
      end
    end else if (!w_run) begin
      if (ucode_we) r_ucode[ucode_addr] <= ucode_data;
      if (disp_we) begin
        if (disp_sel) r_d2[disp_addr] <= disp_data;
        else          r_d1[disp_addr] <= disp_data;
      end
    end
  end

  assign upc     = r_upc;
  assign busy    = w_run;
  assign done    = w_end;
  assign stall   = w_run && w_gated && !inp_valid;
  assign cfg_err = r_wr_rej || (w_run && w_illegal);

endmodule
